// File: rtl/mul_div_unit_if.sv
// Bundle between the E-stage control path and the multiply/divide unit.
// The master drives the operation request and reads back Busy and HI/LO.
interface mul_div_unit_if;
  logic        Start;
  logic [3:0]  MDUOP;
  logic [3:0]  Time;
  logic [31:0] A;
  logic [31:0] B;
  logic [1:0]  ReadHILO;
  logic        Busy;
  logic [31:0] MDUOut;
  logic [31:0] HI;
  logic [31:0] LO;

  modport master (
    output Start, MDUOP, Time, A, B, ReadHILO,
    input  Busy, MDUOut, HI, LO
  );

  modport slave (
    input  Start, MDUOP, Time, A, B, ReadHILO,
    output Busy, MDUOut, HI, LO
  );
endinterface

// File: rtl/mul_div_unit.sv
// Multiply/divide unit: HI/LO registers, pending results and a countdown.
// Results are computed at the start edge and retired when the count expires.
module mul_div_unit (
  input  logic          clk,
  input  logic          reset,
  mul_div_unit_if.slave bus
);
  typedef enum logic {IDLE, RUN} state_t;

  state_t      state;
  logic [31:0] hi, lo;
  logic [31:0] tmpHI, tmpLO;
  logic [3:0]  cnt;
  logic        busy;

  logic        is_mult, is_multu, is_div, is_divu;
  logic        is_mthi, is_mtlo, go, div0, ovf;
  logic [63:0] prod_s, prod_u;
  logic signed [31:0] sa, sb, q_s, r_s;
  logic [31:0] nhi, nlo;
  logic [3:0]  lat;

  assign is_mult  = bus.MDUOP == 4'b0001;
  assign is_multu = bus.MDUOP == 4'b0010;
  assign is_div   = bus.MDUOP == 4'b0011;
  assign is_divu  = bus.MDUOP == 4'b0100;
  assign is_mthi  = bus.MDUOP == 4'b0101;
  assign is_mtlo  = bus.MDUOP == 4'b0110;

  assign go = (state == IDLE) && bus.Start &&
              (is_mult | is_multu | is_div | is_divu);

  assign sa     = $signed(bus.A);
  assign sb     = $signed(bus.B);
  assign prod_s = $signed({{32{bus.A[31]}}, bus.A}) *
                  $signed({{32{bus.B[31]}}, bus.B});
  assign prod_u = {32'd0, bus.A} * {32'd0, bus.B};
  assign div0   = bus.B == 32'd0;
  assign ovf    = (bus.A == 32'h8000_0000) &&
                  (bus.B == 32'hFFFF_FFFF);
  assign q_s    = div0 ? 32'sd0 : sa / sb;
  assign r_s    = div0 ? 32'sd0 : sa % sb;
  assign lat    = (bus.Time == 4'd0) ? 4'd1 : bus.Time;

  // Result of the requested op; a zero divisor keeps HI/LO as they are
  always_comb begin
    nhi = hi;
    nlo = lo;
    unique case (1'b1)
      is_mult: begin
        nhi = prod_s[63:32];
        nlo = prod_s[31:0];
      end
      is_multu: begin
        nhi = prod_u[63:32];
        nlo = prod_u[31:0];
      end
      is_div: begin
        if (ovf) begin
          nhi = 32'd0;
          nlo = 32'h8000_0000;
        end else if (!div0) begin
          nhi = r_s;
          nlo = q_s;
        end
      end
      is_divu: begin
        if (!div0) begin
          nhi = bus.A % bus.B;
          nlo = bus.A / bus.B;
        end
      end
      default: ;
    endcase
  end

  // Two-state sequencer: accept in IDLE, count down and retire in RUN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      hi    <= 32'd0;
      lo    <= 32'd0;
      tmpHI <= 32'd0;
      tmpLO <= 32'd0;
      cnt   <= 4'd0;
      busy  <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (go) begin
            tmpHI <= nhi;
            tmpLO <= nlo;
            cnt   <= lat;
            busy  <= 1'b1;
            state <= RUN;
          end else if (is_mthi) begin
            hi <= bus.A;
          end else if (is_mtlo) begin
            lo <= bus.A;
          end
        end
        RUN: begin
          cnt <= cnt - 4'd1;
          if (cnt == 4'd1) begin
            hi    <= tmpHI;
            lo    <= tmpLO;
            busy  <= 1'b0;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // MFHI/MFLO read path sees only the architectural registers
  always_comb begin
    unique case (bus.ReadHILO)
      2'b10:   bus.MDUOut = hi;
      2'b01:   bus.MDUOut = lo;
      default: bus.MDUOut = 32'd0;
    endcase
  end

  assign bus.Busy = busy;
  assign bus.HI   = hi;
  assign bus.LO   = lo;
endmodule
